// File: rtl/cpu16_core.sv
// Single-cycle 16-bit core: 16-word instruction memory, 16-word data RAM,
// 16x16 register file and ALU; one instruction fetched, executed and committed per clock.
module cpu16_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_we,
  input  logic [3:0]  imem_waddr,
  input  logic [15:0] imem_wdata,
  input  logic [3:0]  dbg_sel,
  output logic [15:0] dbg_reg,
  output logic [3:0]  pc,
  output logic [15:0] instr,
  output logic [15:0] alu_out,
  output logic        carry,
  output logic        halted
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_ADDI = 4'h1,
    OP_SUB  = 4'h2,
    OP_SUBI = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NOR  = 4'h7,
    OP_NAND = 4'h8,
    OP_HALT = 4'h9,
    OP_LSL  = 4'hA,
    OP_NOP  = 4'hB,
    OP_BEQ  = 4'hC,
    OP_B    = 4'hD,
    OP_STUR = 4'hE,
    OP_LDUR = 4'hF
  } opcode_e;

  logic [15:0] imem_q [16];
  logic [15:0] imem_d [16];
  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];
  logic [15:0] ram_q  [16];
  logic [15:0] ram_d  [16];
  logic [3:0]  pc_q, pc_d;
  logic        carry_q, carry_d;
  logic        halted_q, halted_d;

  opcode_e     op;
  logic [3:0]  rd, rn, rm;
  logic [15:0] rn_val, rm_val, imm;
  logic [16:0] alu_wide;
  logic        alu_en;
  logic        alu_sets_carry;

  assign instr   = imem_q[pc_q];
  assign op      = opcode_e'(instr[15:12]);
  assign rd      = instr[11:8];
  assign rn      = instr[7:4];
  assign rm      = instr[3:0];
  assign rn_val  = regs_q[rn];
  assign rm_val  = regs_q[rm];
  assign imm     = {12'h000, rm};

  assign pc      = pc_q;
  assign carry   = carry_q;
  assign halted  = halted_q;
  assign dbg_reg = regs_q[dbg_sel];
  assign alu_out = alu_wide[15:0];

  // Bit 16 of the 17-bit difference is exactly the unsigned borrow (A < B).
  always_comb begin
    alu_wide       = '0;
    alu_en         = 1'b1;
    alu_sets_carry = 1'b0;
    case (op)
      OP_ADD: begin
        alu_wide       = {1'b0, rn_val} + {1'b0, rm_val};
        alu_sets_carry = 1'b1;
      end
      OP_ADDI: begin
        alu_wide       = {1'b0, rn_val} + {1'b0, imm};
        alu_sets_carry = 1'b1;
      end
      OP_SUB: begin
        alu_wide       = {1'b0, rn_val} - {1'b0, rm_val};
        alu_sets_carry = 1'b1;
      end
      OP_SUBI: begin
        alu_wide       = {1'b0, rn_val} - {1'b0, imm};
        alu_sets_carry = 1'b1;
      end
      OP_AND:  alu_wide = {1'b0, rn_val & rm_val};
      OP_OR:   alu_wide = {1'b0, rn_val | rm_val};
      OP_XOR:  alu_wide = {1'b0, rn_val ^ rm_val};
      OP_NOR:  alu_wide = {1'b0, ~(rn_val | rm_val)};
      OP_NAND: alu_wide = {1'b0, ~(rn_val & rm_val)};
      OP_LSL:  alu_wide = {1'b0, rn_val << rm};
      default: alu_en   = 1'b0;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    carry_d  = carry_q;
    halted_d = halted_q;
    regs_d   = regs_q;
    ram_d    = ram_q;
    if (!halted_q) begin
      pc_d = pc_q + 4'd1;
      if (alu_en) begin
        regs_d[rd] = alu_out;
        if (alu_sets_carry) carry_d = alu_wide[16];
      end
      case (op)
        OP_HALT: begin
          halted_d = 1'b1;
          pc_d     = pc_q;
        end
        OP_BEQ:  if (rn_val == imm) pc_d = pc_q + rd;
        OP_B:    pc_d = pc_q - rd;
        OP_STUR: ram_d[rd] = rn_val;
        OP_LDUR: regs_d[rn] = ram_q[rd];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
      regs_q   <= '{default: '0};
      ram_q    <= '{default: '0};
    end else begin
      pc_q     <= pc_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
      regs_q   <= regs_d;
      ram_q    <= ram_d;
    end
  end

  // Program store survives reset and stays writable while halted.
  always_comb begin
    imem_d = imem_q;
    if (imem_we) imem_d[imem_waddr] = imem_wdata;
  end

  always_ff @(posedge clk) begin
    imem_q <= imem_d;
  end

endmodule

// File: tb/tb_cpu16_core.sv
// Bench for cpu16_core: directed test-plan programs plus random programs,
// all checked cycle by cycle against an arithmetic reference model.
module tb_cpu16_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_we = 1'b0;
  logic [3:0]  imem_waddr = '0;
  logic [15:0] imem_wdata = '0;
  logic [3:0]  dbg_sel = '0;
  logic [15:0] dbg_reg;
  logic [3:0]  pc;
  logic [15:0] instr;
  logic [15:0] alu_out;
  logic        carry;
  logic        halted;

  cpu16_core dut (
    .clk(clk), .rst(rst), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .dbg_sel(dbg_sel), .dbg_reg(dbg_reg), .pc(pc),
    .instr(instr), .alu_out(alu_out), .carry(carry), .halted(halted)
  );

  always #20 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference machine state
  logic [15:0] m_imem [16];
  int unsigned m_regs [16];
  int unsigned m_ram  [16];
  int unsigned m_pc;
  bit          m_carry;
  bit          m_halted;

  logic [15:0] prog [16];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_carry = 0; m_halted = 0;
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 0;
      m_ram[i]  = 0;
    end
  endfunction

  function automatic void model_alu(input logic [15:0] w, output int unsigned res,
                                    output bit is_alu, output bit sets_c, output bit c);
    int unsigned op, a, b, k;
    op = w[15:12]; a = m_regs[w[7:4]]; b = m_regs[w[3:0]]; k = w[3:0];
    res = 0; is_alu = 1; sets_c = 0; c = 0;
    case (op)
      0:  begin res = (a + b) % 65536; c = (a + b) > 65535; sets_c = 1; end
      1:  begin res = (a + k) % 65536; c = (a + k) > 65535; sets_c = 1; end
      2:  begin res = (a + 65536 - b) % 65536; c = a < b; sets_c = 1; end
      3:  begin res = (a + 65536 - k) % 65536; c = a < k; sets_c = 1; end
      4:  res = a & b;
      5:  res = a | b;
      6:  res = a ^ b;
      7:  res = 65535 - (a | b);
      8:  res = 65535 - (a & b);
      10: res = (a * (1 << k)) % 65536;
      default: is_alu = 0;
    endcase
  endfunction

  // Applies one rising edge to the model using the inputs the DUT sees at that edge.
  function automatic void model_step();
    logic [15:0] w;
    int unsigned res, op, rd, rn, rm, npc;
    bit is_alu, sets_c, c;
    w = m_imem[m_pc];
    if (rst) begin
      model_reset();
    end else if (!m_halted) begin
      model_alu(w, res, is_alu, sets_c, c);
      op = w[15:12]; rd = w[11:8]; rn = w[7:4]; rm = w[3:0];
      npc = (m_pc + 1) % 16;
      if (is_alu) begin
        m_regs[rd] = res;
        if (sets_c) m_carry = c;
      end else begin
        case (op)
          9:  begin m_halted = 1; npc = m_pc; end
          12: if (m_regs[rn] == rm) npc = (m_pc + rd) % 16;
          13: npc = (m_pc + 16 - rd) % 16;
          14: m_ram[rd] = m_regs[rn];
          15: m_regs[rn] = m_ram[rd];
          default: ;
        endcase
      end
      m_pc = npc;
    end
    if (imem_we) m_imem[imem_waddr] = imem_wdata;
  endfunction

  task automatic tick();
    int unsigned res;
    bit is_alu, sets_c, c;
    int unsigned sel;
    model_alu(m_imem[m_pc], res, is_alu, sets_c, c);
    check_eq("instr", instr, m_imem[m_pc]);
    check_eq("alu_out", alu_out, is_alu ? res : 0);
    @(posedge clk);
    model_step();
    #1;
    check_eq("pc", pc, m_pc);
    check_eq("halted", halted, m_halted);
    check_eq("carry", carry, m_carry);
    sel = $urandom_range(15);
    dbg_sel = sel[3:0];
    #1;
    check_eq($sformatf("dbg_reg[%0d]", sel), dbg_reg, m_regs[sel]);
  endtask

  task automatic read_reg(input int r, output logic [15:0] v);
    dbg_sel = r[3:0];
    #1;
    v = dbg_reg;
  endtask

  task automatic check_all_regs(input string tag);
    logic [15:0] v;
    for (int r = 0; r < 16; r++) begin
      read_reg(r, v);
      check_eq($sformatf("%s_r%0d", tag, r), v, m_regs[r]);
    end
  endtask

  task automatic load_prog();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      imem_we = 1'b1; imem_waddr = i[3:0]; imem_wdata = prog[i];
      @(posedge clk);
      model_step();
      #1;
    end
    imem_we = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, output int beq_t, output int beq_nt, output int bj);
    logic [3:0]  p;
    logic [15:0] iw;
    beq_t = 0; beq_nt = 0; bj = 0;
    for (int cyc = 0; cyc < 200 && !halted; cyc++) begin
      p = pc; iw = instr;
      tick();
      if (iw[15:12] == 4'hC) begin
        if (pc == p + 4'd3) beq_t++;
        else if (pc == p + 4'd1) beq_nt++;
      end
      if (iw[15:12] == 4'hD && p == 4'd7 && pc == 4'd2) bj++;
    end
    check_eq({tag, "_halted"}, halted, 1);
  endtask

  task automatic check_fib(input string tag);
    logic [15:0] v;
    int t, nt, bj;
    run_to_halt(tag, t, nt, bj);
    check_eq({tag, "_pc"}, pc, 9);
    read_reg(4, v); check_eq({tag, "_r4"}, v, 16'h0037);
    read_reg(5, v); check_eq({tag, "_r5"}, v, 16'h0000);
    check_eq({tag, "_beq_taken"}, t, 1);
    check_eq({tag, "_beq_not_taken"}, nt, 8);
    check_eq({tag, "_b_7_to_2"}, bj, 8);
  endtask

  logic [15:0] alu_exp [7] = '{16'h0FFF, 16'hF1E1, 16'h0000, 16'h0FFF, 16'h0FFF, 16'hF000, 16'hFFFF};

  initial begin
    logic [15:0] v;
    int unsigned wrd;

    // ALU sweep
    prog = '{16'h110F, 16'hA114, 16'h120F, 16'hA228, 16'h122F,
             16'h0312, 16'h2312, 16'h4312, 16'h5312, 16'h6312, 16'h7312, 16'h8312,
             16'h9000, 16'h9000, 16'h9000, 16'h9000};
    load_prog();
    repeat (5) tick();
    read_reg(1, v); check_eq("sweep_r1", v, 16'h00F0);
    read_reg(2, v); check_eq("sweep_r2", v, 16'h0F0F);
    for (int i = 0; i < 7; i++) begin
      tick();
      read_reg(3, v); check_eq($sformatf("sweep_op%0d_r3", i), v, alu_exp[i]);
      if (i == 1) check_eq("sweep_sub_carry", carry, 1);
    end
    tick();
    check_eq("sweep_halted", halted, 1);

    // Carry on overflow, then LSL with R1 = 1
    prog = '{16'h3101, 16'h1111, 16'h1111, 16'hA21F, 16'hA310, 16'h9000,
             16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h9000,
             16'h9000, 16'h9000, 16'h9000, 16'h9000};
    load_prog();
    tick(); read_reg(1, v); check_eq("subi_wrap", v, 16'hFFFF); check_eq("subi_carry", carry, 1);
    tick(); read_reg(1, v); check_eq("addi_wrap", v, 16'h0000); check_eq("addi_carry", carry, 1);
    tick(); read_reg(1, v); check_eq("addi_one", v, 16'h0001); check_eq("addi_nocarry", carry, 0);
    tick(); read_reg(2, v); check_eq("lsl15", v, 16'h8000);
    tick(); read_reg(3, v); check_eq("lsl0", v, 16'h0001);

    // Memory store / load, then load after reset
    prog = '{16'h1101, 16'hA114, 16'h1112, 16'hA114, 16'h1113, 16'hA114, 16'h1114,
             16'hE710, 16'hF750, 16'h9000, 16'h9000, 16'h9000, 16'h9000,
             16'h9000, 16'h9000, 16'h9000};
    load_prog();
    repeat (7) tick();
    read_reg(1, v); check_eq("mem_r1", v, 16'h1234);
    repeat (2) tick();
    read_reg(5, v); check_eq("mem_ldur", v, 16'h1234);
    prog = '{16'hF750, 16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h9000,
             16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h9000,
             16'h9000, 16'h9000, 16'h9000};
    load_prog();
    tick();
    read_reg(5, v); check_eq("mem_ldur_after_rst", v, 16'h0000);

    // Fibonacci, hold after halt, async reset mid-run, rerun
    prog = '{16'h1201, 16'h1509, 16'h0423, 16'h0320, 16'h0240, 16'h3551, 16'hC350,
             16'hD500, 16'h0000, 16'h9000, 16'h9000, 16'h9000, 16'h9000,
             16'h9000, 16'h9000, 16'h9000};
    load_prog();
    check_fib("fib");
    repeat (5) tick();
    check_eq("fib_hold_pc", pc, 9);
    check_all_regs("fib_hold");
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
    repeat (12) tick();
    #5;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("arst_pc", pc, 0);
    check_eq("arst_halted", halted, 0);
    for (int r = 0; r < 16; r++) begin
      read_reg(r, v);
      check_eq($sformatf("arst_r%0d", r), v, 16'h0000);
    end
    rst = 1'b0;
    check_fib("fib_rerun");

    // Random programs with random IMem writes during execution
    for (int p = 0; p < 15; p++) begin
      for (int i = 0; i < 16; i++) begin
        wrd = $urandom_range(65535);
        if (wrd[15:12] == 4'h9 && $urandom_range(3) != 0) wrd[15:12] = 4'hB;
        prog[i] = wrd[15:0];
      end
      load_prog();
      for (int c = 0; c < 40; c++) begin
        if ($urandom_range(3) == 0) begin
          imem_we = 1'b1;
          wrd = $urandom_range(65535);
          imem_wdata = (wrd[15:12] == 4'h9) ? {4'hB, wrd[11:0]} : wrd[15:0];
          imem_waddr = (c % 5 == 0) ? pc : 4'($urandom_range(15));
        end
        tick();
        imem_we = 1'b0;
      end
      check_all_regs($sformatf("rand%0d", p));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
